// File: rtl/fft_bin_serializer_if.sv
// Bus bundle for fft_bin_serializer: wide FFT frame in, one complex bin per valid/ready handshake out.
// bin_mag is present only when FFT_SER_MAG_EN is defined.
interface fft_bin_serializer_if #(
  parameter int unsigned N          = 16,
  parameter int unsigned DATA_WIDTH = 4
);
  localparam int unsigned IDX_W   = $clog2(N);
  localparam int unsigned FRAME_W = N * 2 * DATA_WIDTH;

  logic [FRAME_W-1:0]    frame_in;
  logic                  en_in;
  logic                  bin_ready;
  logic                  ovf_clr;
  logic [DATA_WIDTH-1:0] bin_re;
  logic [DATA_WIDTH-1:0] bin_im;
  logic [IDX_W-1:0]      bin_idx;
  logic                  bin_valid;
  logic                  bin_last;
  logic                  ovf;

`ifdef FFT_SER_MAG_EN
  logic [DATA_WIDTH:0]   bin_mag;

  modport master (
    output frame_in, en_in, bin_ready, ovf_clr,
    input  bin_re, bin_im, bin_idx, bin_valid, bin_last, ovf, bin_mag
  );

  modport slave (
    input  frame_in, en_in, bin_ready, ovf_clr,
    output bin_re, bin_im, bin_idx, bin_valid, bin_last, ovf, bin_mag
  );
`else
  modport master (
    output frame_in, en_in, bin_ready, ovf_clr,
    input  bin_re, bin_im, bin_idx, bin_valid, bin_last, ovf
  );

  modport slave (
    input  frame_in, en_in, bin_ready, ovf_clr,
    output bin_re, bin_im, bin_idx, bin_valid, bin_last, ovf
  );
`endif

endinterface

// File: rtl/fft_bin_serializer.sv
// Captures full FFT frames and streams them one complex bin per handshake, bin 0 first,
// with one frame of skid buffering. Optional |re|+|im| output enabled by FFT_SER_MAG_EN.
module fft_bin_serializer #(
  parameter int unsigned N          = 16,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  fft_bin_serializer_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(N);
  localparam int unsigned BIN_W   = 2 * DATA_WIDTH;
  localparam int unsigned FRAME_W = N * BIN_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    EMPTY       = 2'd0,
    STREAM      = 2'd1,
    STREAM_HELD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] out_q, out_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;

  logic               xfer;
  logic               drain;
  logic               drop;

  // OUT is a shift register: the presented bin always sits in the top BIN_W bits.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    drop    = 1'b0;
    xfer    = valid_q && bus.bin_ready;
    drain   = xfer && (idx_q == LAST_IDX);

    if (xfer && !drain) begin
      out_d = out_q << BIN_W;
      idx_d = idx_q + IDX_W'(1);
    end

    unique case (state_q)
      EMPTY: begin
        if (bus.en_in) begin
          out_d   = bus.frame_in;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (drain) begin
          idx_d = '0;
          if (bus.en_in) begin
            out_d = bus.frame_in;
          end else begin
            state_d = EMPTY;
          end
        end else if (bus.en_in) begin
          hold_d  = bus.frame_in;
          state_d = STREAM_HELD;
        end
      end
      STREAM_HELD: begin
        if (drain) begin
          out_d = hold_q;
          idx_d = '0;
          if (bus.en_in) begin
            hold_d = bus.frame_in;
          end else begin
            state_d = STREAM;
          end
        end else if (bus.en_in) begin
          drop = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    endcase

    valid_d = (state_d != EMPTY);

    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d = ovf_q;
    if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.bin_re    = out_q[FRAME_W-1 -: DATA_WIDTH];
  assign bus.bin_im    = out_q[FRAME_W-DATA_WIDTH-1 -: DATA_WIDTH];
  assign bus.bin_idx   = idx_q;
  assign bus.bin_valid = valid_q;
  assign bus.bin_last  = valid_q && (idx_q == LAST_IDX);
  assign bus.ovf       = ovf_q;

`ifdef FFT_SER_MAG_EN
  localparam int unsigned MAG_W = DATA_WIDTH + 1;

  logic signed [MAG_W-1:0] re_s, im_s;
  logic        [MAG_W-1:0] re_abs, im_abs;

  // One extra bit makes the most-negative component's magnitude representable.
  always_comb begin
    re_s   = MAG_W'($signed(bus.bin_re));
    im_s   = MAG_W'($signed(bus.bin_im));
    re_abs = re_s[MAG_W-1] ? $unsigned(-re_s) : $unsigned(re_s);
    im_abs = im_s[MAG_W-1] ? $unsigned(-im_s) : $unsigned(im_s);
  end

  assign bus.bin_mag = re_abs + im_abs;
`endif

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Scoreboard bench for fft_bin_serializer: frame-occupancy reference model feeds an expected-bin
// queue; a negedge monitor checks every handshake, stall stability, valid, last and ovf.
module tb_fft_bin_serializer;

  localparam int unsigned N       = 16;
  localparam int unsigned DW      = 4;
  localparam int unsigned BIN_W   = 2 * DW;
  localparam int unsigned FRAME_W = N * BIN_W;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  fft_bin_serializer_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  fft_bin_serializer #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            idx;
  } bin_t;

  bin_t          exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            occ   = 0;   // frames held by the serializer (0..2)
  int            midx  = 0;   // index of the bin being presented
  int            m_ovf = 0;
  logic [DW-1:0] cur_re[N];
  logic [DW-1:0] cur_im[N];

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at t=%0t", name, $time);
  endfunction

  function automatic int sabs(logic [DW-1:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  // Reference model: counts stored frames; a new frame fits if fewer than two remain after this edge.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_q.delete();
      occ   = 0;
      midx  = 0;
      m_ovf = 0;
    end else begin : model_step
      bit moving;
      bit finished;
      moving   = (occ > 0) && bus.bin_ready;
      finished = moving && (midx == N - 1);
      if (moving) midx = finished ? 0 : midx + 1;
      if (finished) occ--;
      if (bus.en_in && occ < 2) begin
        for (int k = 0; k < N; k++) exp_q.push_back('{cur_re[k], cur_im[k], k});
        occ++;
        if (bus.ovf_clr) m_ovf = 0;
      end else if (bus.en_in) begin
        m_ovf = 1;
      end else if (bus.ovf_clr) begin
        m_ovf = 0;
      end
    end
  end

  logic [DW-1:0] p_re, p_im;
  int            p_idx;
  bit            p_stall = 1'b0;

  always @(negedge clk) begin
    if (n_rst) begin : monitor
      bin_t e;
      check("valid", int'(bus.bin_valid), int'(occ > 0));
      check("last", int'(bus.bin_last), int'(occ > 0 && midx == N - 1));
      check("ovf", int'(bus.ovf), m_ovf);
      if (p_stall) begin
        check("stall_re", int'(bus.bin_re), int'(p_re));
        check("stall_im", int'(bus.bin_im), int'(p_im));
        check("stall_idx", int'(bus.bin_idx), p_idx);
      end
      if (bus.bin_valid) check("idx", int'(bus.bin_idx), midx);
      if (bus.bin_valid && bus.bin_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_bin");
        end else begin
          e = exp_q.pop_front();
          check("bin_re", int'(bus.bin_re), int'(e.re));
          check("bin_im", int'(bus.bin_im), int'(e.im));
          check("bin_idx", int'(bus.bin_idx), e.idx);
`ifdef FFT_SER_MAG_EN
          check("bin_mag", int'(bus.bin_mag), sabs(e.re) + sabs(e.im));
`endif
        end
      end
      p_stall = bus.bin_valid && !bus.bin_ready;
      p_re    = bus.bin_re;
      p_im    = bus.bin_im;
      p_idx   = int'(bus.bin_idx);
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // mode 1: bin k = {re=k, im=-k}; mode 0: random components
  task automatic set_frame(input int mode);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) begin
      cur_re[k] = (mode == 1) ? DW'(k)  : DW'($urandom);
      cur_im[k] = (mode == 1) ? DW'(-k) : DW'($urandom);
      f[(N - k) * BIN_W - 1 -: BIN_W] = {cur_re[k], cur_im[k]};
    end
    bus.frame_in = f;
  endtask

  task automatic send(input int mode);
    set_frame(mode);
    bus.en_in = 1'b1;
    tick();
    bus.en_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(bus.bin_valid), 0);
    check({tag, "_last"}, int'(bus.bin_last), 0);
    check({tag, "_idx"}, int'(bus.bin_idx), 0);
    check({tag, "_re"}, int'(bus.bin_re), 0);
    check({tag, "_im"}, int'(bus.bin_im), 0);
    check({tag, "_ovf"}, int'(bus.ovf), 0);
  endtask

  initial begin
    #1_000_000;
    fail_now("watchdog_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    n_rst         = 1'b1;
    bus.en_in     = 1'b0;
    bus.bin_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    bus.frame_in  = '0;
    for (int k = 0; k < N; k++) begin
      cur_re[k] = '0;
      cur_im[k] = '0;
    end
    #1 n_rst = 1'b0;
    #11;
    check_all_zero("reset");
    @(posedge clk);
    #2 n_rst = 1'b1;

    // single ramp frame with ready held high
    bus.bin_ready = 1'b1;
    send(1);
    repeat (20) tick();

    // backpressure pattern 1,0,0
    set_frame(0);
    bus.en_in = 1'b1;
    for (int c = 0; c < 60; c++) begin
      bus.bin_ready = (c % 3 == 0);
      tick();
      bus.en_in = 1'b0;
    end
    bus.bin_ready = 1'b1;
    repeat (5) tick();

    // overflow: three strobes two cycles apart while stalled
    bus.bin_ready = 1'b0;
    send(0); tick();
    send(0); tick();
    send(0); tick();
    repeat (3) tick();
    check("ovf_set", int'(bus.ovf), 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", int'(bus.ovf), 0);
    bus.bin_ready = 1'b1;
    repeat (36) tick();

    // new frame lands on the edge where the full HOLD moves to OUT
    send(0); tick();
    send(0);
    w = 0;
    while (!bus.bin_last && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) fail_now("wait_first_last");
    send(0);
    check("simul_ovf", int'(bus.ovf), 0);
    repeat (40) tick();

    // frames every N cycles with ready high never overflow
    for (int f = 0; f < 6; f++) begin
      send(0);
      repeat (N - 1) tick();
    end
    repeat (20) tick();
    check("spacing_ovf", int'(bus.ovf), 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.bin_ready = ($urandom_range(0, 3) != 0);
      bus.ovf_clr   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) begin
        set_frame(0);
        bus.en_in = 1'b1;
      end else begin
        bus.en_in = 1'b0;
      end
      tick();
    end
    bus.en_in     = 1'b0;
    bus.ovf_clr   = 1'b1;
    bus.bin_ready = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    repeat (40) tick();

    // asynchronous reset while presenting bin 5
    send(1);
    w = 0;
    while (bus.bin_idx != 5 && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) fail_now("wait_idx5");
    #1 n_rst = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (20) tick();
    check("post_rst_valid", int'(bus.bin_valid), 0);

    // one more frame after reset, then confirm everything drained
    send(1);
    repeat (25) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
